dispatch_queue: RTL and testbench

Parametrised in-order dispatch queue between decode and the rename/RS-allocation logic. Accepts up to IN_W decoded instructions per cycle into a circular buffer. Each cycle it dispatches up to OUT_W of the oldest entries, stopping at the first structural hazard (ROB slots, free physical registers, per-RS-bank credits). It adds three things the single-cycle dispatch stage lacks: cross-cycle buffering, credit-based RS accounting and halt serialisation.

---
 rtl/dispatch_queue_pkg.sv | 72 +++++++
 rtl/dispatch_queue_select.sv | 85 ++++++++
 rtl/dispatch_queue.sv | 170 +++++++++++++++++
 tb/tb_dispatch_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared entry types, sizes and RS bank mapping for the dispatch queue
package dispatch_queue_pkg;

  localparam int N                = 3;
  localparam int ROB_SZ           = 32;
  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int ROB_CNT_W        = $clog2(ROB_SZ + 1);
  localparam int PHYS_CNT_W       = $clog2(PHYS_REG_SZ_R10K + 1);

  typedef enum logic [2:0] {
    CAT_ALU,
    CAT_MULT,
    CAT_BRANCH,
    CAT_MEM,
    CAT_SYS
  } op_category_e;

  typedef struct packed {
    op_category_e category;
    logic [3:0]   func;
  } op_type_t;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] inst;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic        uses_rd;
    op_type_t    op_type;
    logic [1:0]  opa_select;
    logic [1:0]  opb_select;
    logic        rs2_immediate;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        halt;
  } disp_q_entry_t;

  typedef enum logic [2:0] {
    RS_ALU    = 3'd0,
    RS_MULT   = 3'd1,
    RS_BRANCH = 3'd2,
    RS_MEM    = 3'd3,
    RS_NONE   = 3'd7
  } rs_bank_idx_e;

  typedef enum logic [2:0] {
    STALL_NONE,
    STALL_ROB,
    STALL_PHYS,
    STALL_BANK,
    STALL_HALT
  } stall_cause_e;

  // Only the fields the hazard scan needs, so the scanner sees no unused payload.
  typedef struct packed {
    logic         uses_rd;
    op_category_e category;
    logic         halt;
  } scan_info_t;

  function automatic rs_bank_idx_e bank_of(input op_category_e category);
    case (category)
      CAT_ALU:    return RS_ALU;
      CAT_MULT:   return RS_MULT;
      CAT_BRANCH: return RS_BRANCH;
      CAT_MEM:    return RS_MEM;
      default:    return RS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_queue_select.sv
// rtl/dispatch_queue_select.sv - combinational in-order hazard scan over the head window
// Optional head stall cause output when DISP_Q_STALL_STATS_EN is defined.
module dispatch_queue_select
  import dispatch_queue_pkg::*;
#(
  parameter int OUT_W      = N,
  parameter int NUM_BANKS  = 4,
  parameter int CREDIT_MAX = 16,
  localparam int CW = $clog2(CREDIT_MAX + 1),
  localparam int RW = $clog2(OUT_W + 1)
) (
  input  scan_info_t            win [OUT_W],
  input  logic [RW-1:0]         avail,
  input  logic [ROB_CNT_W-1:0]  rob_free,
  input  logic [PHYS_CNT_W-1:0] phys_free,
  input  logic [CW-1:0]         credits [NUM_BANKS],
  input  logic                  halt_seen,
  output logic [RW-1:0]         deq_count,
  output logic [RW-1:0]         bank_used [NUM_BANKS],
  output logic                  halt_hit,
`ifdef DISP_Q_STALL_STATS_EN
  output stall_cause_e          head_cause,
`endif
  output logic                  unmapped
);

  int           used [NUM_BANKS];
  int           rob_used;
  int           phys_used;
  int           cnt;
  int           b;
  logic         stop;
  stall_cause_e cause;

  always_comb begin
    rob_used  = 0;
    phys_used = 0;
    cnt       = 0;
    b         = 0;
    stop      = 1'b0;
    cause     = STALL_NONE;
    halt_hit  = 1'b0;
    unmapped  = 1'b0;
`ifdef DISP_Q_STALL_STATS_EN
    head_cause = STALL_NONE;
`endif
    for (int j = 0; j < NUM_BANKS; j++) used[j] = 0;

    for (int k = 0; k < OUT_W; k++) begin
      if (!stop && k < int'(avail)) begin
        b     = int'(bank_of(win[k].category));
        cause = STALL_NONE;
        if (rob_used >= int'(rob_free)) cause = STALL_ROB;
        else if (win[k].uses_rd && phys_used >= int'(phys_free)) cause = STALL_PHYS;
        else if (b >= NUM_BANKS) begin
          cause    = STALL_BANK;
          unmapped = 1'b1;
        end
        else if (int'(credits[b]) - used[b] <= 0) cause = STALL_BANK;
        else if (halt_seen) cause = STALL_HALT;

        if (cause != STALL_NONE) begin
          stop = 1'b1;
`ifdef DISP_Q_STALL_STATS_EN
          if (k == 0) head_cause = cause;
`endif
        end else begin
          cnt      = cnt + 1;
          rob_used = rob_used + 1;
          if (win[k].uses_rd) phys_used = phys_used + 1;
          used[b] = used[b] + 1;
          // A halt closes the dispatch group so nothing younger leaves with it.
          if (win[k].halt) begin
            stop     = 1'b1;
            halt_hit = 1'b1;
          end
        end
      end
    end

    deq_count = RW'(cnt);
    for (int j = 0; j < NUM_BANKS; j++) bank_used[j] = RW'(used[j]);
  end

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order dispatch queue with RS bank credits and halt serialisation
// Optional stall_cnt counters when DISP_Q_STALL_STATS_EN is defined.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int IN_W       = N,
  parameter int OUT_W      = N,
  parameter int DEPTH      = 8,
  parameter int NUM_BANKS  = 4,
  parameter int CREDIT_MAX = 16,
  localparam int CW = $clog2(CREDIT_MAX + 1),
  localparam int RW = $clog2(OUT_W + 1),
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [IN_W-1:0]       in_valid,
  input  disp_q_entry_t         in_entries [IN_W],
  output logic                  in_ready,
  input  logic [ROB_CNT_W-1:0]  rob_free_slots,
  input  logic [PHYS_CNT_W-1:0] phys_free_slots,
  input  logic [RW-1:0]         bank_credit_return [NUM_BANKS],
  output logic [OUT_W-1:0]      out_valid,
  output disp_q_entry_t         out_entries [OUT_W],
  output logic [RW-1:0]         out_count,
  output logic [CW-1:0]         bank_credits [NUM_BANKS],
`ifdef DISP_Q_STALL_STATS_EN
  output logic [31:0]           stall_cnt [4],
`endif
  output logic [OW-1:0]         occupancy
);

  disp_q_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [OW-1:0] count;
  logic          halt_seen;

  disp_q_entry_t win  [OUT_W];
  scan_info_t    info [OUT_W];
  logic [RW-1:0] avail;
  logic [RW-1:0] deq_count;
  logic [RW-1:0] bank_used [NUM_BANKS];
  logic          halt_hit;
  logic          unmapped;
  logic          enq;
  int            enq_n;
  int            credit_sum;
  logic [CW-1:0] credit_next [NUM_BANKS];
  logic          credit_ovf;

`ifdef DISP_Q_STALL_STATS_EN
  stall_cause_e  head_cause;
`endif

  always_comb begin
    for (int k = 0; k < OUT_W; k++) begin
      win[k]  = mem[head + PW'(k)];
      info[k] = '{uses_rd: win[k].uses_rd, category: win[k].op_type.category, halt: win[k].halt};
    end
    avail = (int'(count) < OUT_W) ? RW'(count) : RW'(OUT_W);
  end

  dispatch_queue_select #(
    .OUT_W      (OUT_W),
    .NUM_BANKS  (NUM_BANKS),
    .CREDIT_MAX (CREDIT_MAX)
  ) u_select (
    .win        (info),
    .avail      (avail),
    .rob_free   (rob_free_slots),
    .phys_free  (phys_free_slots),
    .credits    (bank_credits),
    .halt_seen  (halt_seen),
    .deq_count  (deq_count),
    .bank_used  (bank_used),
    .halt_hit   (halt_hit),
`ifdef DISP_Q_STALL_STATS_EN
    .head_cause (head_cause),
`endif
    .unmapped   (unmapped)
  );

  // in_ready looks only at the registered count; same-cycle dequeues help next cycle.
  assign in_ready  = (DEPTH - int'(count)) >= IN_W;
  assign occupancy = count;

  always_comb begin
    enq_n = 0;
    for (int i = 0; i < IN_W; i++) enq_n = enq_n + int'(in_valid[i]);
    enq = in_ready && (|in_valid) && !flush;
  end

  always_comb begin
    out_count = flush ? '0 : deq_count;
    out_valid = '0;
    for (int k = 0; k < OUT_W; k++) begin
      out_valid[k]   = k < int'(out_count);
      out_entries[k] = out_valid[k] ? win[k] : '0;
    end
  end

  // Squashed slots come back through bank_credit_return, so returns apply even on flush.
  always_comb begin
    credit_ovf = 1'b0;
    credit_sum = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      credit_sum = int'(bank_credits[b]) - (flush ? 0 : int'(bank_used[b]))
                   + int'(bank_credit_return[b]);
      if (credit_sum > CREDIT_MAX) begin
        credit_next[b] = CW'(CREDIT_MAX);
        credit_ovf     = 1'b1;
      end else begin
        credit_next[b] = CW'(credit_sum);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) bank_credits[b] <= CW'(CREDIT_MAX);
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) bank_credits[b] <= credit_next[b];
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        halt_seen <= 1'b0;
      end else begin
        head  <= head + PW'(deq_count);
        if (enq) tail <= tail + PW'(enq_n);
        count <= OW'(int'(count) + (enq ? enq_n : 0) - int'(deq_count));
        if (halt_hit) halt_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      for (int i = 0; i < IN_W; i++) begin
        if (in_valid[i]) mem[tail + PW'(i)] <= in_entries[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) assert (!unmapped);
    if (!reset) assert (!credit_ovf);
  end

`ifdef DISP_Q_STALL_STATS_EN
  int stall_idx;
  assign stall_idx = int'(head_cause) - 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stall_cnt[i] <= '0;
    end else if (!flush && count != '0 && out_count == '0 && head_cause != STALL_NONE) begin
      if (stall_cnt[stall_idx] != '1) stall_cnt[stall_idx] <= stall_cnt[stall_idx] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench for dispatch_queue directed scenarios
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int IN_W = 3, OUT_W = 3, DEPTH = 8, NUM_BANKS = 4, CREDIT_MAX = 16;
  localparam int RW = 2, CW = 5, OW = 4;
  localparam int B_ALU = 0, B_MULT = 1, B_MEM = 3;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  flush;
  logic [IN_W-1:0]       in_valid;
  disp_q_entry_t         in_entries [IN_W];
  logic                  in_ready;
  logic [ROB_CNT_W-1:0]  rob_free_slots;
  logic [PHYS_CNT_W-1:0] phys_free_slots;
  logic [RW-1:0]         bank_credit_return [NUM_BANKS];
  logic [OUT_W-1:0]      out_valid;
  disp_q_entry_t         out_entries [OUT_W];
  logic [RW-1:0]         out_count;
  logic [CW-1:0]         bank_credits [NUM_BANKS];
  logic [OW-1:0]         occupancy;
`ifdef DISP_Q_STALL_STATS_EN
  logic [31:0]           stall_cnt [4];
`endif

  int n_cmp = 0;
  int n_err = 0;
  disp_q_entry_t sb[$];
  disp_q_entry_t exp_e;

  always #5 clock = ~clock;

  dispatch_queue #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS), .CREDIT_MAX(CREDIT_MAX)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_entries         (in_entries),
    .in_ready           (in_ready),
    .rob_free_slots     (rob_free_slots),
    .phys_free_slots    (phys_free_slots),
    .bank_credit_return (bank_credit_return),
    .out_valid          (out_valid),
    .out_entries        (out_entries),
    .out_count          (out_count),
    .bank_credits       (bank_credits),
`ifdef DISP_Q_STALL_STATS_EN
    .stall_cnt          (stall_cnt),
`endif
    .occupancy          (occupancy)
  );

  function automatic disp_q_entry_t mk(input logic [31:0] pc, input op_category_e cat, input logic h);
    disp_q_entry_t e;
    e = '0;
    e.PC               = pc;
    e.inst             = pc ^ 32'h0000_1357;
    e.rd_idx           = pc[6:2];
    e.rs1_idx          = pc[11:7];
    e.uses_rd          = 1'b1;
    e.op_type.category = cat;
    e.pred_target      = pc + 32'd4;
    e.halt             = h;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer n lanes: lane 0 uses c0, the rest cr; exp_m marks lanes expected to dispatch.
  task automatic put(input int n, input op_category_e c0, input op_category_e cr,
                     input logic [31:0] pc0, input logic [2:0] halt_m, input logic [2:0] exp_m);
    in_valid = '0;
    for (int i = 0; i < IN_W; i++) begin
      in_entries[i] = mk(pc0 + 32'(4 * i), (i == 0) ? c0 : cr, halt_m[i]);
      if (i < n) begin
        in_valid[i] = 1'b1;
        if (exp_m[i]) sb.push_back(in_entries[i]);
      end
    end
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < OUT_W; k++) begin
        if (out_valid[k]) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: lane %0d pc=%h, expected no dispatch", k, out_entries[k].PC);
          end else begin
            exp_e = sb.pop_front();
            if (out_entries[k] !== exp_e) begin
              n_err++;
              $display("FAIL sb_entry: lane %0d pc=%h halt=%0d, expected pc=%h halt=%0d",
                       k, out_entries[k].PC, out_entries[k].halt, exp_e.PC, exp_e.halt);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = '0;
    rob_free_slots = 6'd16;
    phys_free_slots = 7'd16;
    for (int b = 0; b < NUM_BANKS; b++) bank_credit_return[b] = '0;
    for (int i = 0; i < IN_W; i++) in_entries[i] = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_entry0_pc", out_entries[0].PC, 0);
    for (int b = 0; b < NUM_BANKS; b++) chk("rst_credit", bank_credits[b], CREDIT_MAX);

    // Three ALU ops, no same-cycle bypass
    put(3, CAT_ALU, CAT_ALU, 32'h100, 3'b000, 3'b111);
    #1 chk("t1_no_bypass", out_count, 0);
    step(); idle(); #1;
    chk("t1_out_count", out_count, 3);
    chk("t1_occ_before", occupancy, 3);
    step(); #1;
    chk("t1_alu_credit", bank_credits[B_ALU], 13);
    chk("t1_occ_after", occupancy, 0);

    // ROB limit splits the group
    rob_free_slots = 6'd1;
    put(3, CAT_ALU, CAT_ALU, 32'h200, 3'b000, 3'b111);
    step(); idle(); #1;
    chk("t2_rob1_count", out_count, 1);
    step(); rob_free_slots = 6'd8; #1;
    chk("t2_rest_count", out_count, 2);
    step(); #1;
    chk("t2_occ", occupancy, 0);
    chk("t2_alu_credit", bank_credits[B_ALU], 10);
    bank_credit_return[B_ALU] = 2'd3;
    step(); bank_credit_return[B_ALU] = '0; #1;
    chk("t2_alu_return", bank_credits[B_ALU], 13);

    // Drain MULT credits, then MULT blocks the ALU op behind it
    for (int g = 0; g < 6; g++) begin
      put((g < 5) ? 3 : 1, CAT_MULT, CAT_MULT, 32'h3000 + 32'(g * 16), 3'b000, 3'b111);
      step();
    end
    idle(); step(); step(); #1;
    chk("t3_mult_drained", bank_credits[B_MULT], 0);
    chk("t3_occ_drained", occupancy, 0);
    put(2, CAT_MULT, CAT_ALU, 32'h3400, 3'b000, 3'b011);
    step(); idle(); #1;
    chk("t3_blocked_a", out_count, 0);
    step(); bank_credit_return[B_MULT] = 2'd1; #1;
    chk("t3_blocked_b", out_count, 0);
    step(); bank_credit_return[B_MULT] = '0; #1;
    chk("t3_unblocked", out_count, 2);
    step(); #1;
    chk("t3_occ", occupancy, 0);
    chk("t3_mult_credit", bank_credits[B_MULT], 0);
    chk("t3_alu_credit", bank_credits[B_ALU], 12);

    // Halt serialisation, then flush recovers
    put(3, CAT_ALU, CAT_ALU, 32'h4000, 3'b010, 3'b011);
    step(); idle(); #1;
    chk("t4_halt_count", out_count, 2);
    step(); #1;
    chk("t4_halt_held_a", out_count, 0);
    chk("t4_halt_occ", occupancy, 1);
    step(); flush = 1'b1; #1;
    chk("t4_halt_held_b", out_count, 0);
    step(); flush = 1'b0; #1;
    chk("t4_flush_occ", occupancy, 0);
    put(3, CAT_ALU, CAT_ALU, 32'h4100, 3'b000, 3'b111);
    step(); idle(); #1;
    chk("t4_after_flush", out_count, 3);
    step(); #1;
    chk("t4_alu_credit", bank_credits[B_ALU], 7);

    // Fill across the pointer wrap; in_ready drops at six entries
    rob_free_slots = 6'd0;
    put(3, CAT_MEM, CAT_MEM, 32'h5000, 3'b000, 3'b111);
    step(); #1;
    chk("t5_occ3", occupancy, 3);
    chk("t5_ready3", in_ready, 1);
    put(3, CAT_MEM, CAT_MEM, 32'h5010, 3'b000, 3'b111);
    step(); #1;
    chk("t5_occ6", occupancy, 6);
    chk("t5_ready6", in_ready, 0);
    chk("t5_rob0_count", out_count, 0);
    put(3, CAT_MEM, CAT_MEM, 32'h5020, 3'b000, 3'b000);
    step(); idle(); rob_free_slots = 6'd2; #1;
    chk("t5_not_consumed", occupancy, 6);
    chk("t5_rob2_count", out_count, 2);
    step(); #1;
    chk("t5_occ4", occupancy, 4);
    chk("t5_ready4", in_ready, 1);
    put(3, CAT_MEM, CAT_MEM, 32'h5030, 3'b000, 3'b111);
    #1 chk("t5_enq_deq_count", out_count, 2);
    step(); idle(); rob_free_slots = 6'd16; #1;
    chk("t5_occ5", occupancy, 5);
    step(); step(); #1;
    chk("t5_drain_occ", occupancy, 0);
    chk("t5_mem_credit", bank_credits[B_MEM], 7);

    // Flush with simultaneous enqueue and credit return
    put(2, CAT_ALU, CAT_ALU, 32'h6000, 3'b000, 3'b000);
    step();
    flush = 1'b1;
    put(3, CAT_ALU, CAT_ALU, 32'h6100, 3'b000, 3'b000);
    bank_credit_return[B_ALU] = 2'd2;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_count", out_count, 0);
    step(); flush = 1'b0; idle(); bank_credit_return[B_ALU] = '0; #1;
    chk("t6_occ", occupancy, 0);
    chk("t6_alu_credit", bank_credits[B_ALU], 9);
    step(); #1;
    chk("t6_idle_count", out_count, 0);

    step();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
